// File: rtl/edge_betweenness_if.sv
// Bundles the request/result signals of the edge betweenness engine.
// The master side drives the graph and the start request; the slave side is
// the engine that returns the removed edge and the status flags.
interface edge_betweenness_if #(
    parameter int CW = 8
);
    logic          start;
    logic [0:255]  graph_in;
    logic [0:255]  reach_in;
    logic [0:1023] pred_in;
    logic          busy;
    logic          done;
    logic [0:255]  graph_out;
    logic [3:0]    edge_u;
    logic [3:0]    edge_v;
    logic [CW-1:0] max_count;
    logic          none_found;
    logic          err;

    modport master (
        output start, graph_in, reach_in, pred_in,
        input  busy, done, graph_out, edge_u, edge_v, max_count, none_found, err
    );

    modport slave (
        input  start, graph_in, reach_in, pred_in,
        output busy, done, graph_out, edge_u, edge_v, max_count, none_found, err
    );
endinterface

// File: rtl/edge_betweenness.sv
// Edge betweenness on a 16-node graph: walks every reachable shortest path
// through the supplied predecessor table, counts how often each undirected
// edge is crossed, then removes the most-crossed edge (earliest pair on ties).
module edge_betweenness #(
    parameter int MAX = 16,
    parameter int CW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    edge_betweenness_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAIR,
        STEP,
        SCAN,
        DONE
    } state_t;

    state_t        state;

    // Snapshot of the request, held for the whole computation
    logic [0:255]  graph_l;
    logic [0:255]  reach_l;
    logic [0:1023] pred_l;

    // Crossing counters; only entries with u < v are ever used
    logic [CW-1:0] cnt [0:MAX-1][0:MAX-1];

    // Shared pair index: (s,d) during PAIR/STEP, (i,j) during SCAN
    logic [7:0]    idx;
    logic [3:0]    node;
    logic [3:0]    hops;

    // Best candidate found so far in SCAN
    logic          have;
    logic [CW-1:0] best;
    logic [3:0]    best_u;
    logic [3:0]    best_v;

    logic [3:0]    s;
    logic [3:0]    d;
    logic [3:0]    pred_p;
    logic          edge_ok;
    logic [3:0]    lo;
    logic [3:0]    hi;
    logic          last_pair;

    logic          next_have;
    logic [CW-1:0] next_best;
    logic [3:0]    next_u;
    logic [3:0]    next_v;
    logic [0:255]  graph_cut;

    assign s         = idx[7:4];
    assign d         = idx[3:0];
    assign last_pair = (idx == 8'hFF);

    // One hop of the predecessor walk: the hop p->node must be a real edge
    assign pred_p  = pred_l[{s, node, 2'b00} +: 4];
    assign edge_ok = graph_l[{pred_p, node}];
    assign lo      = (pred_p < node) ? pred_p : node;
    assign hi      = (pred_p < node) ? node : pred_p;

    // Candidate update for the pair (i,j) = (s,d) currently being scanned
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch
        // is inferred on paths that do not update it.
        next_have = have;
        next_best = best;
        next_u    = best_u;
        next_v    = best_v;
        if ((s < d) && (graph_l[{s, d}] || graph_l[{d, s}])) begin
            if (!have || (cnt[s][d] > best)) begin
                next_have = 1'b1;
                next_best = cnt[s][d];
                next_u    = s;
                next_v    = d;
            end
        end
        graph_cut = graph_l;
        graph_cut[{next_u, next_v}] = 1'b0;
        graph_cut[{next_v, next_u}] = 1'b0;
    end

    // Control FSM, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples its inputs from before this edge.
            state          <= IDLE;
            graph_l        <= '0;
            reach_l        <= '0;
            pred_l         <= '0;
            idx            <= '0;
            node           <= '0;
            hops           <= '0;
            have           <= 1'b0;
            best           <= '0;
            best_u         <= '0;
            best_v         <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.graph_out  <= '0;
            bus.edge_u     <= '0;
            bus.edge_v     <= '0;
            bus.max_count  <= '0;
            bus.none_found <= 1'b0;
            bus.err        <= 1'b0;
            // NOTE: the counter array is cleared on reset as well, because a
            // reset mid-run must leave no stale crossing counts behind.
            for (int u = 0; u < MAX; u++) begin
                for (int v = 0; v < MAX; v++) begin
                    cnt[u][v] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        graph_l        <= bus.graph_in;
                        reach_l        <= bus.reach_in;
                        pred_l         <= bus.pred_in;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.graph_out  <= '0;
                        bus.edge_u     <= '0;
                        bus.edge_v     <= '0;
                        bus.max_count  <= '0;
                        bus.none_found <= 1'b0;
                        bus.err        <= 1'b0;
                        state          <= LOAD;
                    end
                end

                LOAD: begin
                    for (int u = 0; u < MAX; u++) begin
                        for (int v = u + 1; v < MAX; v++) begin
                            cnt[u][v] <= '0;
                        end
                    end
                    idx    <= '0;
                    have   <= 1'b0;
                    best   <= '0;
                    best_u <= '0;
                    best_v <= '0;
                    state  <= PAIR;
                end

                PAIR: begin
                    if ((s != d) && reach_l[idx]) begin
                        node  <= d;
                        hops  <= '0;
                        state <= STEP;
                    end else begin
                        idx <= idx + 8'd1;
                        if (last_pair) begin
                            state <= SCAN;
                        end
                    end
                end

                STEP: begin
                    if (!edge_ok || (hops == 4'd15)) begin
                        bus.err        <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.graph_out  <= graph_l;
                        bus.edge_u     <= '0;
                        bus.edge_v     <= '0;
                        bus.max_count  <= '0;
                        bus.none_found <= 1'b0;
                        state          <= DONE;
                    end else begin
                        if (cnt[lo][hi] != {CW{1'b1}}) begin
                            cnt[lo][hi] <= cnt[lo][hi] + CW'(1);
                        end
                        node <= pred_p;
                        hops <= hops + 4'd1;
                        if (pred_p == s) begin
                            idx   <= idx + 8'd1;
                            state <= last_pair ? SCAN : PAIR;
                        end
                    end
                end

                SCAN: begin
                    have   <= next_have;
                    best   <= next_best;
                    best_u <= next_u;
                    best_v <= next_v;
                    idx    <= idx + 8'd1;
                    if (last_pair) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                        if (next_have) begin
                            bus.graph_out  <= graph_cut;
                            bus.edge_u     <= next_u;
                            bus.edge_v     <= next_v;
                            bus.max_count  <= next_best;
                            bus.none_found <= 1'b0;
                        end else begin
                            bus.graph_out  <= graph_l;
                            bus.edge_u     <= '0;
                            bus.edge_v     <= '0;
                            bus.max_count  <= '0;
                            bus.none_found <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_betweenness.sv
// Directed bench for edge_betweenness: each run pushes its expected result
// into a scoreboard when start is driven and pops it when done appears.
module tb_edge_betweenness;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    edge_betweenness_if #(.CW(8)) bus ();

    edge_betweenness #(.MAX(16), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:255] g;
        logic [3:0]   u;
        logic [3:0]   v;
        logic [7:0]   mc;
        logic         nf;
        logic         er;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   t0;

    function automatic logic [0:255] add_edge(input logic [0:255] g, input int a, input int b);
        g[16*a+b] = 1'b1;
        g[16*b+a] = 1'b1;
        return g;
    endfunction

    function automatic logic [0:255] full_reach(input int n);
        logic [0:255] r;
        r = '0;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++)
                if (a != b) r[16*a+b] = 1'b1;
        return r;
    endfunction

    function automatic logic [0:1023] set_pred(input logic [0:1023] p, input int s, input int d,
                                               input logic [3:0] v);
        p[4*(16*s+d) +: 4] = v;
        return p;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [0:255] g, input logic [0:255] r, input logic [0:1023] p);
        @(negedge clk);
        bus.graph_in = g;
        bus.reach_in = r;
        bus.pred_in  = p;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = cyc;
        check("busy_after_start", bus.busy, 1'b1);
    endtask

    task automatic finish_run(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sbq.pop_front();
        check({name, " done"},       bus.done, 1'b1);
        check({name, " latency"},    cyc - t0, e.lat);
        check({name, " busy"},       bus.busy, 1'b0);
        check({name, " graph_out"},  bus.graph_out, e.g);
        check({name, " edge_u"},     bus.edge_u, e.u);
        check({name, " edge_v"},     bus.edge_v, e.v);
        check({name, " max_count"},  bus.max_count, e.mc);
        check({name, " none_found"}, bus.none_found, e.nf);
        check({name, " err"},        bus.err, e.er);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, bus.done, 1'b0);
        check({name, " hold_graph"}, bus.graph_out, e.g);
    endtask

    task automatic check_cleared(input string name);
        check({name, " busy"},       bus.busy, 1'b0);
        check({name, " done"},       bus.done, 1'b0);
        check({name, " graph_out"},  bus.graph_out, '0);
        check({name, " edge_u"},     bus.edge_u, '0);
        check({name, " edge_v"},     bus.edge_v, '0);
        check({name, " max_count"},  bus.max_count, '0);
        check({name, " none_found"}, bus.none_found, 1'b0);
        check({name, " err"},        bus.err, 1'b0);
    endtask

    logic [0:255]  g_path, g_path_cut, r3, g_star, g_star_cut, r4;
    logic [0:1023] p_path, p_bad, p_star;
    exp_t          e_path, e_star, e_empty, e_bad;

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.graph_in = '0;
        bus.reach_in = '0;
        bus.pred_in  = '0;

        // Path 0-1-2 with shortest-path predecessors
        g_path     = add_edge(add_edge('0, 0, 1), 1, 2);
        g_path_cut = add_edge('0, 1, 2);
        r3         = full_reach(3);
        p_path     = '0;
        p_path     = set_pred(p_path, 0, 1, 4'd0);
        p_path     = set_pred(p_path, 0, 2, 4'd1);
        p_path     = set_pred(p_path, 1, 0, 4'd1);
        p_path     = set_pred(p_path, 1, 2, 4'd1);
        p_path     = set_pred(p_path, 2, 0, 4'd1);
        p_path     = set_pred(p_path, 2, 1, 4'd2);
        p_bad      = set_pred(p_path, 0, 2, 4'd3);

        // Star centred on 0 with leaves 1..3
        g_star     = add_edge(add_edge(add_edge('0, 0, 1), 0, 2), 0, 3);
        g_star_cut = add_edge(add_edge('0, 0, 2), 0, 3);
        r4         = full_reach(4);
        p_star     = '0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                if (a != b) p_star = set_pred(p_star, a, b, (a == 0) ? 4'd0 : ((b == 0) ? 4'(a) : 4'd0));

        e_path  = '{g: g_path_cut, u: 4'd0, v: 4'd1, mc: 8'd4, nf: 1'b0, er: 1'b0, lat: 521};
        e_star  = '{g: g_star_cut, u: 4'd0, v: 4'd1, mc: 8'd6, nf: 1'b0, er: 1'b0, lat: 531};
        e_empty = '{g: '0,         u: 4'd0, v: 4'd0, mc: 8'd0, nf: 1'b1, er: 1'b0, lat: 513};
        e_bad   = '{g: g_path,     u: 4'd0, v: 4'd0, mc: 8'd0, nf: 1'b0, er: 1'b1, lat: 6};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Path graph: tie between (0,1) and (1,2) keeps (0,1)
        launch(g_path, r3, p_path);
        sbq.push_back(e_path);
        finish_run("path");

        // Star: three-way tie keeps (0,1)
        launch(g_star, r4, p_star);
        sbq.push_back(e_star);
        finish_run("star");

        // Empty graph
        launch('0, '0, '0);
        sbq.push_back(e_empty);
        finish_run("empty");

        // Inconsistent predecessor on pair (0,2)
        launch(g_path, r3, p_bad);
        sbq.push_back(e_bad);
        finish_run("bad_pred");

        // Reset during the first STEP of the path run, then rerun cleanly
        launch(g_path, r3, p_path);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        launch(g_path, r3, p_path);
        sbq.push_back(e_path);
        finish_run("after_reset");

        // A second start while busy (with different inputs) is ignored
        launch(g_path, r3, p_path);
        sbq.push_back(e_path);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.graph_in = g_star;
        bus.reach_in = r4;
        bus.pred_in  = p_star;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_run("double_start");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
